// File: rtl/ex_operand_stage_pkg.sv
// Shared constants and types for the EX operand-issue stage.
//   - ALU operation codes (shared encoding with the ALU)
//   - operand-select constants and FSM state encodings
//   - forwarding-source tuple and the EX segment register layout
package ex_operand_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Operand selects
    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;
    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StWait = 1'b1
    } ex_state_e;

    // Destination tuple of a downstream stage that may supply a forwarded value
    typedef struct packed {
        logic            valid;
        logic            reg_wr;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] result;
    } fwd_src_t;

    // ID/EX segment register payload
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic            reg_wr;
        logic            is_load;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            op1_sel;
        logic            op2_sel;
        logic [3:0]      alu_func;
    } ex_fields_t;

    // A stage supplies rs only if it really writes a non-x0 register equal to rs
    function automatic logic src_match(input fwd_src_t src, input logic [REGW-1:0] rs);
        return src.valid && src.reg_wr && (src.rd != '0) && (src.rd == rs);
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bus bundle of the EX operand stage.
//   master: pipeline side (drives ID fields, MEM/WB status, flush/stall; reads ALU operands)
//   slave : the operand stage itself
interface ex_operand_stage_if;
    import ex_operand_stage_pkg::*;

    logic            flush_i;
    logic            stall_i;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic            id_reg_wr;
    logic            id_is_load;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_op1_sel;
    logic            id_op2_sel;
    logic [3:0]      id_alu_func;
    logic            mem_valid;
    logic            mem_reg_wr;
    logic            mem_is_load;
    logic [REGW-1:0] mem_rd;
    logic [XLEN-1:0] mem_result;
    logic            wb_valid;
    logic            wb_reg_wr;
    logic [REGW-1:0] wb_rd;
    logic [XLEN-1:0] wb_result;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      alu_func;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_wr;
    logic            ex_is_load;
    logic [XLEN-1:0] ex_store_data;
    logic            id_stall_o;

    modport master (
        output flush_i, stall_i, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_reg_wr,
               id_is_load, id_rs1_data, id_rs2_data, id_imm, id_op1_sel, id_op2_sel,
               id_alu_func, mem_valid, mem_reg_wr, mem_is_load, mem_rd, mem_result,
               wb_valid, wb_reg_wr, wb_rd, wb_result,
        input  op1, op2, alu_func, ex_valid, ex_pc, ex_rd, ex_reg_wr, ex_is_load,
               ex_store_data, id_stall_o
    );

    modport slave (
        input  flush_i, stall_i, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_reg_wr,
               id_is_load, id_rs1_data, id_rs2_data, id_imm, id_op1_sel, id_op2_sel,
               id_alu_func, mem_valid, mem_reg_wr, mem_is_load, mem_rd, mem_result,
               wb_valid, wb_reg_wr, wb_rd, wb_result,
        output op1, op2, alu_func, ex_valid, ex_pc, ex_rd, ex_reg_wr, ex_is_load,
               ex_store_data, id_stall_o
    );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Forwarding mux for one source register.
//   rs_i, reg_data_i       : source index and its stored register value
//   mem_src_i, wb_src_i    : MEM / WB destination tuples
//   mem_is_load_i          : MEM holds a load (its result is an address, not data)
//   data_o                 : forwarded value (MEM over WB over register)
//   load_hit_o             : rs is produced by the load currently in MEM
module ex_operand_stage_fwd_mux
    import ex_operand_stage_pkg::*;
(
    input  logic [REGW-1:0] rs_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  fwd_src_t        mem_src_i,
    input  logic            mem_is_load_i,
    input  fwd_src_t        wb_src_i,
    output logic [XLEN-1:0] data_o,
    output logic            load_hit_o
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit    = src_match(mem_src_i, rs_i);
        wb_hit     = src_match(wb_src_i, rs_i);
        load_hit_o = mem_hit && mem_is_load_i;
        if (mem_hit) begin
            data_o = mem_src_i.result;
        end else if (wb_hit) begin
            data_o = wb_src_i.result;
        end else begin
            data_o = reg_data_i;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX segment register and operand issue for the ALU.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : ID fields, MEM/WB forwarding status, flush/stall in;
//                ALU operands, EX control and ID stall out
// A load in MEM feeding the EX instruction costs one bubble: the EX slot is
// presented invalid for a cycle while the load moves to WB, then reissues with
// the WB value.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    ex_operand_stage_if.slave bus
);

    ex_fields_t      ex_q, ex_d;
    logic            valid_q, valid_d;
    ex_state_e       state_q, state_d;

    fwd_src_t        mem_src;
    fwd_src_t        wb_src;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            load_hit_rs1;
    logic            load_hit_rs2;
    logic            load_use;

    assign mem_src = '{valid: bus.mem_valid, reg_wr: bus.mem_reg_wr,
                       rd: bus.mem_rd, result: bus.mem_result};
    assign wb_src  = '{valid: bus.wb_valid, reg_wr: bus.wb_reg_wr,
                       rd: bus.wb_rd, result: bus.wb_result};

    ex_operand_stage_fwd_mux u_fwd_rs1 (
        .rs_i          (ex_q.rs1),
        .reg_data_i    (ex_q.rs1_data),
        .mem_src_i     (mem_src),
        .mem_is_load_i (bus.mem_is_load),
        .wb_src_i      (wb_src),
        .data_o        (fwd_rs1),
        .load_hit_o    (load_hit_rs1)
    );

    ex_operand_stage_fwd_mux u_fwd_rs2 (
        .rs_i          (ex_q.rs2),
        .reg_data_i    (ex_q.rs2_data),
        .mem_src_i     (mem_src),
        .mem_is_load_i (bus.mem_is_load),
        .wb_src_i      (wb_src),
        .data_o        (fwd_rs2),
        .load_hit_o    (load_hit_rs2)
    );

    // Both sources are checked even if the select ignores one (conservative).
    // In WAIT the load has moved to WB, so no new interlock is raised.
    assign load_use = (state_q == StRun) && valid_q && (load_hit_rs1 || load_hit_rs2);

    always_comb begin
        ex_d    = ex_q;
        valid_d = valid_q;
        state_d = state_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
            state_d = StRun;
        end else if (bus.stall_i || load_use) begin
            // Holding: refresh stored operands so a value retiring from WB is kept
            ex_d.rs1_data = fwd_rs1;
            ex_d.rs2_data = fwd_rs2;
            if (!bus.stall_i) begin
                state_d = StWait;
            end
        end else begin
            ex_d = '{pc: bus.id_pc, rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd,
                     reg_wr: bus.id_reg_wr, is_load: bus.id_is_load,
                     rs1_data: bus.id_rs1_data, rs2_data: bus.id_rs2_data,
                     imm: bus.id_imm, op1_sel: bus.id_op1_sel, op2_sel: bus.id_op2_sel,
                     alu_func: bus.id_alu_func};
            valid_d = bus.id_valid;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
            state_q <= StRun;
        end else begin
            ex_q    <= ex_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        bus.op1           = (ex_q.op1_sel == OP1_PC) ? ex_q.pc : fwd_rs1;
        bus.op2           = (ex_q.op2_sel == OP2_IMM) ? ex_q.imm : fwd_rs2;
        bus.ex_store_data = fwd_rs2;
        bus.alu_func      = ex_q.alu_func;
        bus.ex_valid      = valid_q && !load_use;
        bus.ex_pc         = ex_q.pc;
        bus.ex_rd         = ex_q.rd;
        bus.ex_reg_wr     = ex_q.reg_wr;
        bus.ex_is_load    = ex_q.is_load;
        bus.id_stall_o    = !bus.flush_i && (bus.stall_i || load_use);
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the EX slot.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    ex_operand_stage_if bus ();

    ex_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of the instruction sitting in EX
    logic        m_valid, m_wait, m_reg_wr, m_is_load, m_s1, m_s2;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_func;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic writes(input logic v, input logic w, input logic [4:0] rd,
                                    input logic [4:0] rs);
        return v && w && rd != 5'd0 && rd == rs;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regv);
        if (writes(bus.mem_valid, bus.mem_reg_wr, bus.mem_rd, rs)) return bus.mem_result;
        if (writes(bus.wb_valid, bus.wb_reg_wr, bus.wb_rd, rs)) return bus.wb_result;
        return regv;
    endfunction

    function automatic logic lhit(input logic [4:0] rs);
        return writes(bus.mem_valid, bus.mem_reg_wr, bus.mem_rd, rs) && bus.mem_is_load;
    endfunction

    function automatic logic exp_lu();
        return !m_wait && m_valid && (lhit(m_rs1) || lhit(m_rs2));
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wait = 0; m_reg_wr = 0; m_is_load = 0; m_s1 = 0; m_s2 = 0;
        m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_func = ALU_ADD;
    endtask

    task automatic model_update();
        logic        lu;
        logic [31:0] f1, f2;
        lu = exp_lu();
        f1 = fwd(m_rs1, m_d1);
        f2 = fwd(m_rs2, m_d2);
        if (bus.flush_i) begin
            m_valid = 0;
            m_wait  = 0;
        end else if (bus.stall_i) begin
            m_d1 = f1;
            m_d2 = f2;
        end else if (lu) begin
            m_d1   = f1;
            m_d2   = f2;
            m_wait = 1;
        end else begin
            m_valid = bus.id_valid;     m_pc = bus.id_pc;
            m_rs1 = bus.id_rs1;         m_rs2 = bus.id_rs2;     m_rd = bus.id_rd;
            m_reg_wr = bus.id_reg_wr;   m_is_load = bus.id_is_load;
            m_d1 = bus.id_rs1_data;     m_d2 = bus.id_rs2_data; m_imm = bus.id_imm;
            m_s1 = bus.id_op1_sel;      m_s2 = bus.id_op2_sel;  m_func = bus.id_alu_func;
            m_wait = 0;
        end
    endtask

    // Payload fields are only meaningful while the slot is valid
    task automatic check_all(input string tag);
        logic        lu, v;
        logic [31:0] f1, f2;
        lu = exp_lu();
        v  = m_valid && !lu;
        f1 = fwd(m_rs1, m_d1);
        f2 = fwd(m_rs2, m_d2);
        chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(v));
        chk({tag, ".id_stall_o"}, 32'(bus.id_stall_o),
            32'(!bus.flush_i && (bus.stall_i || lu)));
        if (v) begin
            chk({tag, ".op1"}, bus.op1, m_s1 ? m_pc : f1);
            chk({tag, ".op2"}, bus.op2, m_s2 ? m_imm : f2);
            chk({tag, ".store"}, bus.ex_store_data, f2);
            chk({tag, ".alu_func"}, 32'(bus.alu_func), 32'(m_func));
            chk({tag, ".ex_pc"}, bus.ex_pc, m_pc);
            chk({tag, ".ex_rd"}, 32'(bus.ex_rd), 32'(m_rd));
            chk({tag, ".ex_reg_wr"}, 32'(bus.ex_reg_wr), 32'(m_reg_wr));
            chk({tag, ".ex_is_load"}, 32'(bus.ex_is_load), 32'(m_is_load));
        end
    endtask

    task automatic at_neg(input string tag);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] d1,
                          input logic [31:0] d2);
        bus.id_valid = v;   bus.id_pc = pc;   bus.id_rs1 = rs1; bus.id_rs2 = rs2;
        bus.id_rd = 5'd1;   bus.id_reg_wr = 1; bus.id_is_load = 0;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = 32'h44;
        bus.id_op1_sel = OP1_RS1; bus.id_op2_sel = OP2_RS2; bus.id_alu_func = ALU_SUB;
    endtask

    task automatic set_mem(input logic v, input logic ld, input logic [4:0] rd,
                           input logic [31:0] r);
        bus.mem_valid = v; bus.mem_reg_wr = 1; bus.mem_is_load = ld;
        bus.mem_rd = rd;   bus.mem_result = r;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] r);
        bus.wb_valid = v; bus.wb_reg_wr = 1; bus.wb_rd = rd; bus.wb_result = r;
    endtask

    initial begin
        rst_n = 0;
        bus.flush_i = 0; bus.stall_i = 0;
        set_id(0, 0, 0, 0, 0, 0);
        set_mem(0, 0, 0, 0);
        set_wb(0, 0, 0);
        model_reset();

        // Reset state
        @(negedge clk);
        chk("rst.ex_valid", 32'(bus.ex_valid), 0);
        chk("rst.alu_func", 32'(bus.alu_func), 32'(ALU_ADD));
        chk("rst.op1", bus.op1, 0);
        chk("rst.op2", bus.op2, 0);
        chk("rst.store", bus.ex_store_data, 0);
        chk("rst.id_stall_o", 32'(bus.id_stall_o), 0);
        @(posedge clk); #1;
        rst_n = 1;

        // MEM over WB priority, then x0 never forwarded
        set_id(1, 32'h100, 5'd5, 5'd0, 32'h99, 32'h0);
        at_neg("load_a"); adv();
        bus.id_valid = 0;
        set_mem(1, 0, 5'd5, 32'h11);
        set_wb(1, 5'd5, 32'h22);
        at_neg("prio_mem");
        chk("prio_mem.op1", bus.op1, 32'h11);
        bus.mem_valid = 0; #1;
        check_all("prio_wb");
        chk("prio_wb.op1", bus.op1, 32'h22);
        set_mem(1, 0, 5'd0, 32'hFF);
        bus.wb_valid = 0; #1;
        check_all("x0");
        chk("x0.op2", bus.op2, 0);
        chk("x0.store", bus.ex_store_data, 0);
        adv();

        // Load-use: one bubble, then reissue with the WB value
        set_mem(0, 0, 0, 0);
        set_id(1, 32'h104, 5'd3, 5'd2, 32'h0, 32'h7);
        at_neg("lu_load"); adv();
        set_id(1, 32'h108, 5'd1, 5'd1, 32'h10, 32'h20);
        set_mem(1, 1, 5'd3, 32'hDEAD);
        at_neg("lu_bubble");
        chk("lu_bubble.ex_valid", 32'(bus.ex_valid), 0);
        chk("lu_bubble.id_stall_o", 32'(bus.id_stall_o), 1);
        adv();
        set_mem(0, 0, 0, 0);
        set_wb(1, 5'd3, 32'hCAFE0000);
        at_neg("lu_wait");
        chk("lu_wait.ex_valid", 32'(bus.ex_valid), 1);
        chk("lu_wait.op1", bus.op1, 32'hCAFE0000);
        chk("lu_wait.id_stall_o", 32'(bus.id_stall_o), 0);
        adv();
        set_wb(0, 0, 0);
        at_neg("lu_next");
        chk("lu_next.ex_pc", bus.ex_pc, 32'h108);

        // Stall refresh: WB value captured while held
        set_id(1, 32'h10C, 5'd7, 5'd0, 32'h5, 32'h0);
        adv(); at_neg("st_load"); adv();
        set_id(1, 32'h110, 5'd2, 5'd2, 32'h1, 32'h2);
        bus.stall_i = 1;
        set_wb(1, 5'd7, 32'h1234);
        at_neg("st_c1");
        chk("st_c1.id_stall_o", 32'(bus.id_stall_o), 1);
        adv();
        set_wb(0, 0, 0);
        at_neg("st_c2"); adv();
        at_neg("st_c3"); adv();
        bus.stall_i = 0;
        at_neg("st_rel");
        chk("st_rel.op1", bus.op1, 32'h1234);
        chk("st_rel.ex_pc", bus.ex_pc, 32'h10C);
        adv();

        // Flush during WAIT
        set_id(1, 32'h200, 5'd4, 5'd0, 32'h0, 32'h0);
        at_neg("fl_load"); adv();
        set_id(1, 32'h204, 5'd1, 5'd1, 32'h3, 32'h3);
        set_mem(1, 1, 5'd4, 32'hBEEF);
        at_neg("fl_bubble");
        chk("fl_bubble.id_stall_o", 32'(bus.id_stall_o), 1);
        adv();
        set_mem(0, 0, 0, 0);
        set_wb(1, 5'd4, 32'h77);
        bus.flush_i = 1;
        at_neg("fl_wait"); adv();
        bus.flush_i = 0;
        set_wb(0, 0, 0);
        set_id(1, 32'h300, 5'd6, 5'd6, 32'h9, 32'h9);
        at_neg("fl_after");
        chk("fl_after.ex_valid", 32'(bus.ex_valid), 0);
        chk("fl_after.id_stall_o", 32'(bus.id_stall_o), 0);
        adv();
        at_neg("fl_enter");
        chk("fl_enter.ex_valid", 32'(bus.ex_valid), 1);
        chk("fl_enter.ex_pc", bus.ex_pc, 32'h300);
        adv();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.flush_i     = ($urandom_range(0, 15) == 0);
            bus.stall_i     = ($urandom_range(0, 7) == 0);
            bus.id_valid    = ($urandom_range(0, 3) != 0);
            bus.id_pc       = $urandom;
            bus.id_rs1      = 5'($urandom_range(0, 7));
            bus.id_rs2      = 5'($urandom_range(0, 7));
            bus.id_rd       = 5'($urandom_range(0, 31));
            bus.id_reg_wr   = 1'($urandom_range(0, 1));
            bus.id_is_load  = 1'($urandom_range(0, 1));
            bus.id_rs1_data = $urandom;
            bus.id_rs2_data = $urandom;
            bus.id_imm      = $urandom;
            bus.id_op1_sel  = 1'($urandom_range(0, 1));
            bus.id_op2_sel  = 1'($urandom_range(0, 1));
            bus.id_alu_func = 4'($urandom_range(0, 15));
            bus.mem_valid   = ($urandom_range(0, 3) != 0);
            bus.mem_reg_wr  = ($urandom_range(0, 3) != 0);
            bus.mem_is_load = ($urandom_range(0, 2) == 0);
            bus.mem_rd      = 5'($urandom_range(0, 7));
            bus.mem_result  = $urandom;
            bus.wb_valid    = ($urandom_range(0, 3) != 0);
            bus.wb_reg_wr   = ($urandom_range(0, 3) != 0);
            bus.wb_rd       = 5'($urandom_range(0, 7));
            bus.wb_result   = $urandom;
            at_neg("rand");
            adv();
        end

        // Asynchronous reset mid-run with a valid instruction in EX
        bus.flush_i = 0; bus.stall_i = 0;
        set_mem(0, 0, 0, 0);
        set_wb(0, 0, 0);
        set_id(1, 32'h400, 5'd2, 5'd3, 32'h5, 32'h6);
        bus.id_alu_func = ALU_XOR;
        at_neg("pre_rst"); adv();
        at_neg("pre_rst2");
        chk("pre_rst2.ex_valid", 32'(bus.ex_valid), 1);
        #2 rst_n = 0;
        #1;
        chk("arst.ex_valid", 32'(bus.ex_valid), 0);
        chk("arst.alu_func", 32'(bus.alu_func), 32'(ALU_ADD));
        chk("arst.op1", bus.op1, 0);
        chk("arst.op2", bus.op2, 0);
        chk("arst.store", bus.ex_store_data, 0);
        chk("arst.id_stall_o", 32'(bus.id_stall_o), 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        at_neg("post_rst"); adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX segment register and operand-issue stage of the RV32I pipeline. It sits directly upstream of the ALU and drives op1, op2 and ALU_func.
- Captures decoded fields from ID and resolves RAW hazards by forwarding from MEM and WB.
- Runs a load-use interlock FSM that inserts one bubble toward the ALU and stalls ID.
- Handles downstream stall and branch flush.

Parameters:
XLEN, 32, datapath width
REGW, 5, register-index width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  kill EX contents (branch/jump taken)
stall_i  in  1  downstream stall: hold everything
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1, id_rs2, id_rd  in  REGW  register indices
id_reg_wr  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  decoded immediate
id_op1_sel  in  1  0=rs1, 1=pc
id_op2_sel  in  1  0=rs2, 1=imm
id_alu_func  in  4  ALU operation code (shared encoding)
mem_valid, mem_reg_wr, mem_is_load  in  1  MEM-stage status
mem_rd  in  REGW  MEM destination
mem_result  in  XLEN  MEM ALU result
wb_valid, wb_reg_wr  in  1  WB-stage status
wb_rd  in  REGW  WB destination
wb_result  in  XLEN  WB write-back value
op1, op2  out  XLEN  ALU operands
alu_func  out  4  ALU operation
ex_valid  out  1  EX slot holds a real instruction this cycle
ex_pc  out  XLEN  PC of EX instruction
ex_rd  out  REGW  destination index
ex_reg_wr, ex_is_load  out  1  forwarded control
ex_store_data  out  XLEN  forwarded rs2 value, for stores
id_stall_o  out  1  hold ID/IF this cycle

Behaviour:
- Reset (async, rst_n=0):
  - All registered fields are 0 and FSM=RUN.
  - ex_valid=0 and alu_func=`ADD code.
  - op1, op2 and ex_store_data are 0, and id_stall_o=0.
- Forwarding (combinational, from registered rs1/rs2 and their data):
  - Priority is MEM, then WB, then the register value.
  - A source matches when the stage is valid, reg_wr=1, rd!=0 and rd==rs.
  - x0 is never forwarded.
- Operands:
  - op1 = op1_sel ? pc : fwd_rs1.
  - op2 = op2_sel ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2.
- Load-use detection:
  - Condition: ex_valid, MEM matches rs1 or rs2, and mem_is_load=1.
  - An operand that op1_sel/op2_sel does not use is still checked (conservative).
- FSM RUN:
  - If load-use holds, go to WAIT. In that cycle ex_valid=0 toward the ALU (bubble), id_stall_o=1, and the EX register holds.
  - Otherwise, when not stalled, load the ID fields (ex_valid <= id_valid).
- FSM WAIT:
  - The load is now in WB, so its value arrives via wb_result.
  - Next cycle the EX register holds, ex_valid re-asserts and the FSM returns to RUN.
  - Latency is exactly one bubble per load-use.
- Operand refresh: every cycle the EX register holds (stall_i, or the load-use cycle), the stored rs1/rs2 data are overwritten with the current forwarded values. This keeps a value that retires from WB during a stall.
- stall_i=1:
  - All registers and the FSM hold, and id_stall_o=1.
  - The operand refresh still applies.
- flush_i=1: next cycle ex_valid=0, FSM=RUN, and the remaining fields are don't-care.
- Precedence: flush_i beats stall_i, which beats load-use, which beats normal advance.
- flush_i during WAIT aborts the WAIT and does not stall ID further.
- No arithmetic is done here. The PC and immediate pass through at full XLEN unchanged.

Decomposition:
- Parameters.v (shared) already holds the ALU_func codes. Add the operand-select constants (OP1_RS1/OP1_PC, OP2_RS2/OP2_IMM) and the FSM state encodings RUN/WAIT there.
- One natural sub-module: fwd_mux. It takes rs, reg value and the MEM/WB tuples and outputs the forwarded value plus a load-hit flag. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Reset mid-run: assert rst_n=0 asynchronously with ex_valid=1 -> ex_valid=0 and alu_func=`ADD at once, with no clock edge needed.
- MEM over WB priority: rs1=5, MEM rd=5 result 0x11, WB rd=5 result 0x22 -> op1=0x11. With the MEM match removed -> op1=0x22.
- x0 not forwarded: rs2=0, MEM rd=0, reg_wr=1, result 0xFF, reg value 0 -> op2=0.
- Load-use: load x3 in MEM, EX instruction reads x3 -> one cycle with ex_valid=0 and id_stall_o=1. The next cycle has ex_valid=1 and op1=wb_result (0xCAFE0000), then normal flow.
- Stall refresh: stall_i=1 for 3 cycles while WB writes x7=0x1234 in cycle 1 and rs1=7 -> after release op1=0x1234, with no WB match present.
- Flush during WAIT: flush_i pulses in the WAIT cycle -> next cycle ex_valid=0, FSM=RUN, id_stall_o=0. The next ID instruction enters the cycle after that.
